// File: rtl/gyro_rst_pkg.sv
// Shared types and defaults for the gyro reset tree: sequencer state encoding,
// default release timing and the soft-reset counter helper.
package gyro_rst_pkg;

    typedef enum logic [1:0] {
        RST_HOLD    = 2'd0,
        RST_RELEASE = 2'd1,
        RST_RUN     = 2'd2,
        RST_SOFT    = 2'd3
    } rst_state_e;

    localparam int unsigned STAGE_GAP_DEF    = 32'd2500;
    localparam int unsigned SOFT_RST_MIN_DEF = 32'd250;
    localparam logic [7:0]  SOFT_CNT_MAX     = 8'd255;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == SOFT_CNT_MAX) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/rstn_seq_if.sv
// Control/status bundle between the reset sequencer (slave) and the command
// path / downstream consumers (master).
interface rstn_seq_if #(
    parameter int unsigned N_STAGES = 3
);
    logic                i_soft_rst;
    logic [N_STAGES-1:0] o_rst_n_stage;
    logic                o_ready;
    logic [7:0]          o_soft_cnt;

    modport slave (
        input  i_soft_rst,
        output o_rst_n_stage,
        output o_ready,
        output o_soft_cnt
    );

    modport master (
        output i_soft_rst,
        input  o_rst_n_stage,
        input  o_ready,
        input  o_soft_cnt
    );
endinterface

// File: rtl/rstn_sync.sv
// Async-assert / sync-deassert reset synchronizer; the output is the last flop
// of a chain that shifts in 1 once the raw reset is released.
module rstn_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_sync
);
    logic [STAGES-1:0] sync_q;

    // Shift register cleared asynchronously, filling with ones after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign o_sync = sync_q[STAGES-1];
endmodule

// File: rtl/rstn_seq.sv
// Reset receiver/sequencer: synchronizes the power-on reset and releases the
// per-subsystem resets one at a time, replaying the sequence on a soft request.
module rstn_seq
    import gyro_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned N_STAGES     = 3,
    parameter int unsigned STAGE_GAP    = STAGE_GAP_DEF,
    parameter int unsigned SOFT_RST_MIN = SOFT_RST_MIN_DEF
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    rstn_seq_if.slave bus
);
    localparam int unsigned CNT_MAX = max_u(STAGE_GAP, SOFT_RST_MIN);
    localparam int unsigned CNT_W   = (CNT_MAX > 32'd1) ? $clog2(CNT_MAX) : 32'd1;
    localparam int unsigned IDX_W   = (N_STAGES > 32'd1) ? $clog2(N_STAGES) : 32'd1;

    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 32'd1);
    localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(SOFT_RST_MIN - 32'd1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 32'd1);

    logic                sync_s;
    rst_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [N_STAGES-1:0] stage_q;
    logic                ready_q;
    logic [7:0]          soft_cnt_q;
    logic [7:0]          soft_cnt_d;
    logic [N_STAGES-1:0] stage_rel_d;

    rstn_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_sync  (sync_s)
    );

    assign soft_cnt_d  = sat_inc8(soft_cnt_q);
    assign stage_rel_d = stage_q | (N_STAGES'(1) << idx_q);

    // Sequencer FSM with gap counter, stage register and status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RST_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            stage_q    <= '0;
            ready_q    <= 1'b0;
            soft_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                RST_HOLD: begin
                    stage_q <= '0;
                    ready_q <= 1'b0;
                    if (sync_s) begin
                        state_q <= RST_RELEASE;
                        cnt_q   <= GAP_LOAD;
                        idx_q   <= '0;
                    end
                end
                RST_RELEASE: begin
                    if (bus.i_soft_rst) begin
                        state_q    <= RST_SOFT;
                        stage_q    <= '0;
                        ready_q    <= 1'b0;
                        cnt_q      <= SOFT_LOAD;
                        soft_cnt_q <= soft_cnt_d;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        stage_q <= stage_rel_d;
                        cnt_q   <= GAP_LOAD;
                        if (idx_q == LAST_IDX) begin
                            state_q <= RST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                RST_RUN: begin
                    if (bus.i_soft_rst) begin
                        state_q    <= RST_SOFT;
                        stage_q    <= '0;
                        ready_q    <= 1'b0;
                        cnt_q      <= SOFT_LOAD;
                        soft_cnt_q <= soft_cnt_d;
                    end
                end
                RST_SOFT: begin
                    stage_q <= '0;
                    ready_q <= 1'b0;
                    // Leave only once the minimum hold is over and the request has dropped.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!bus.i_soft_rst) begin
                        state_q <= RST_RELEASE;
                        cnt_q   <= GAP_LOAD;
                        idx_q   <= '0;
                    end
                end
                default: begin
                    state_q <= RST_HOLD;
                    stage_q <= '0;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign bus.o_rst_n_stage = stage_q;
    assign bus.o_ready       = ready_q;
    assign bus.o_soft_cnt    = soft_cnt_q;
endmodule

// File: tb/tb_rstn_seq.sv
// Self-checking bench for rstn_seq: directed scenarios plus random soft-reset
// traffic, compared each edge against an edge-count model of the release timeline.
module tb_rstn_seq;
  import gyro_rst_pkg::*;

  localparam int SYNC = 2;
  localparam int N    = 3;
  localparam int GAP  = 4;
  localparam int SMIN = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rstn_seq_if #(.N_STAGES(N)) bus ();

  rstn_seq #(
    .SYNC_STAGES(SYNC), .N_STAGES(N), .STAGE_GAP(GAP), .SOFT_RST_MIN(SMIN)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave)
  );

  // Model: 0 = held after power-on, 1 = sequence running since rel_start, 2 = soft hold since soft_edge
  int edge_n, m_mode, hold_edges, rel_start, soft_edge, m_cnt;
  logic [N-1:0] exp_stage;
  logic         exp_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n = 0; m_mode = 0; hold_edges = 0; m_cnt = 0;
    rel_start = 0; soft_edge = 0;
  endtask

  task automatic model_edge();
    int rel;
    if (!rst_n) begin
      hold_edges = 0;
    end else begin
      edge_n++;
      case (m_mode)
        0: begin
          hold_edges++;
          if (hold_edges == SYNC + 1) begin m_mode = 1; rel_start = edge_n; end
        end
        1: if (bus.i_soft_rst) begin
          m_mode = 2; soft_edge = edge_n;
          if (m_cnt < 255) m_cnt++;
        end
        default: if (edge_n >= soft_edge + SMIN && !bus.i_soft_rst) begin
          m_mode = 1; rel_start = edge_n;
        end
      endcase
    end
    if (m_mode == 1) begin
      rel = (edge_n - rel_start) / GAP;
      if (rel > N) rel = N;
      exp_stage = N'((1 << rel) - 1);
      exp_ready = (rel == N);
    end else begin
      exp_stage = '0;
      exp_ready = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("stage", 32'(bus.o_rst_n_stage), 32'(exp_stage));
    chk("ready", 32'(bus.o_ready), 32'(exp_ready));
    chk("soft_cnt", 32'(bus.o_soft_cnt), 32'(m_cnt));
  endtask

  // Called just after an edge: drops reset mid-cycle, checks the outputs clear with no clock, then releases.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_stage", 32'(bus.o_rst_n_stage), 32'd0);
    chk("async_ready", 32'(bus.o_ready), 32'd0);
    chk("async_cnt", 32'(bus.o_soft_cnt), 32'd0);
    model_reset();
    step();
    step();
    #2 rst_n = 1'b1;
  endtask

  task automatic power_up();
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 6)  chk("pu_e6_stage", 32'(bus.o_rst_n_stage), 32'h0);
      if (i == 7)  chk("pu_e7_stage", 32'(bus.o_rst_n_stage), 32'h1);
      if (i == 10) chk("pu_e10_stage", 32'(bus.o_rst_n_stage), 32'h1);
      if (i == 11) chk("pu_e11_stage", 32'(bus.o_rst_n_stage), 32'h3);
      if (i == 14) chk("pu_e14_ready", 32'(bus.o_ready), 32'h0);
      if (i == 15) chk("pu_e15_stage", 32'(bus.o_rst_n_stage), 32'h7);
      if (i == 15) chk("pu_e15_ready", 32'(bus.o_ready), 32'h1);
    end
    chk("pu_soft_cnt", 32'(bus.o_soft_cnt), 32'h0);
  endtask

  initial begin
    bus.i_soft_rst = 1'b0;
    model_reset();
    step();
    step();
    step();
    #2 rst_n = 1'b1;

    // Power-up sequence
    power_up();
    repeat (3) step();

    // Short soft pulse from RUN
    bus.i_soft_rst = 1'b1;
    step();
    bus.i_soft_rst = 1'b0;
    chk("short_stage0", 32'(bus.o_rst_n_stage), 32'h0);
    chk("short_ready0", 32'(bus.o_ready), 32'h0);
    chk("short_cnt", 32'(bus.o_soft_cnt), 32'h1);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 8)  chk("short_s8", 32'(bus.o_rst_n_stage), 32'h0);
      if (k == 9)  chk("short_s9", 32'(bus.o_rst_n_stage), 32'h1);
      if (k == 13) chk("short_s13", 32'(bus.o_rst_n_stage), 32'h3);
      if (k == 16) chk("short_s16_ready", 32'(bus.o_ready), 32'h0);
      if (k == 17) chk("short_s17_ready", 32'(bus.o_ready), 32'h1);
    end

    // Long soft hold: one increment only, stays in SOFT while high
    bus.i_soft_rst = 1'b1;
    repeat (20) step();
    chk("long_cnt", 32'(bus.o_soft_cnt), 32'h2);
    chk("long_stage", 32'(bus.o_rst_n_stage), 32'h0);
    bus.i_soft_rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) chk("long_rel_s5", 32'(bus.o_rst_n_stage), 32'h1);
    end
    repeat (12) step();

    // Abort mid-release: request sampled at E+8 after stage 0 is out
    async_reset();
    repeat (9) step();
    bus.i_soft_rst = 1'b1;
    step();
    bus.i_soft_rst = 1'b0;
    chk("abort_stage", 32'(bus.o_rst_n_stage), 32'h0);
    chk("abort_cnt", 32'(bus.o_soft_cnt), 32'h1);
    repeat (20) step();

    // Async reset mid-release, then the full power-up repeats
    async_reset();
    repeat (8) step();
    async_reset();
    power_up();

    // Random soft traffic with occasional async resets
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 20)) step();
      if ($urandom_range(0, 7) == 0) async_reset();
      bus.i_soft_rst = 1'b1;
      repeat ($urandom_range(1, 8)) step();
      bus.i_soft_rst = 1'b0;
    end
    repeat (20) step();

    // Saturation of the soft-reset counter
    async_reset();
    power_up();
    for (int r = 0; r < 260; r++) begin
      bus.i_soft_rst = 1'b1;
      step();
      bus.i_soft_rst = 1'b0;
      repeat (SMIN) step();
    end
    chk("sat_cnt", 32'(bus.o_soft_cnt), 32'd255);
    bus.i_soft_rst = 1'b1;
    step();
    bus.i_soft_rst = 1'b0;
    chk("sat_hold", 32'(bus.o_soft_cnt), 32'd255);
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
